datapath_unit: RTL and testbench
================================

Name: datapath_unit

Overview:
- Register/ALU datapath driven by the ControlUnit step signals (R1in/R1out, R2in/R2out, Add/Sub/Mul/Div, SelectY, Yin, Zin, Zout).
- Single shared bus, registers R1, R2, Y and Z, and an ALU with single-cycle add/sub and iterative multi-cycle mul/div.
- Returns Busy and status flags so the control unit can stall its step counter.

Parameters:
WIDTH, 8, data width of bus, registers and ALU.

Ports:
Clock  input  1  system clock, rising-edge.
Reset  input  1  asynchronous, active-low reset.
R1in  input  1  load R1 from bus.
R1out  input  1  drive R1 onto bus.
R2in  input  1  load R2 from bus.
R2out  input  1  drive R2 onto bus.
Yin  input  1  load Y from bus.
Zin  input  1  load Z from the ALU result (mul/div start an iterative op).
Zout  input  1  drive Z onto bus.
SelectY  input  1  ALU A operand: 1 = Y, 0 = constant 1.
Add, Sub, Mul, Div  input  1 each  ALU operation select.
ExtLoad  input  1  external preload strobe.
ExtSel  input  1  preload target: 0 = R1, 1 = R2.
ExtData  input  WIDTH  preload value.
Bus  output  WIDTH  current bus value (combinational).
R1Value, R2Value, ZValue  output  WIDTH each  register contents.
Busy  output  1  multi-cycle op in progress.
Zero  output  1  Z == 0.
DivByZero  output  1  sticky divide-by-zero flag.
BusConflict  output  1  sticky multi-driver flag (see Optional Feature).

Behaviour:
- Reset low: R1, R2, Y, Z, Busy, DivByZero, BusConflict and the iteration counter are cleared to 0 immediately. Zero = 1. Any mul/div in progress is aborted with no Z write.
- Bus (combinational) selects priority Zout > R1out > R2out. With no driver, Bus = 0.
- Register loads happen at the rising edge: R1 <= Bus if R1in; R2 <= Bus if R2in; Y <= Bus if Yin. Several loads in one cycle are allowed.
- ExtLoad has priority over R1in/R2in for the selected register.
- A operand = SelectY ? Y : 1. B operand = Bus.
- Op priority when several are asserted: Add > Sub > Mul > Div.
- Add/Sub with Zin: Z <= (A+B) or (A−B), modulo 2^WIDTH, at the same edge. Latency 1.
- Zin with no op asserted: Z <= Bus.
- Mul or Div with Zin, Busy = 0, sampled at edge t0:
  - A and B are captured into internal operand registers.
  - Busy = 1 from t0 until edge t0+WIDTH.
  - At edge t0+WIDTH, Z is written and Busy returns to 0. Busy is high for exactly WIDTH cycles.
  - Mul: shift-add, one bit per cycle. Z = low WIDTH bits of A*B.
  - Div: restoring shift-subtract, one quotient bit per cycle. Z = A/B, truncated.
- Div with B = 0: still takes WIDTH cycles. Z = all ones. DivByZero set at completion and held until reset.
- While Busy = 1:
  - Zin and all op inputs are ignored. No new op starts and Z is not written from the ALU.
  - Zout drives the old Z.
  - R1/R2/Y loads and ExtLoad still work. Captured operands are unaffected.
- Back-to-back ops: Zin+Mul sampled in the same cycle Busy falls is ignored. Starts require Busy = 0 at the sampling edge.
- Zero is combinational from Z.

Optional Feature:
- Macro BUS_CHECK_EN.
- Defined: BusConflict is set at any rising edge where two or more of R1out/R2out/Zout are high, and held until reset. Bus priority is unchanged.
- Undefined: BusConflict is tied to 0 and no detection logic is built.
- The port exists in both cases.

Test Plan:
- Reset mid-op: ExtLoad R1=6, start Mul, assert Reset low for 1 cycle after 3 cycles → all registers 0, Busy 0, Zero 1; Z never written.
- Add: preload R1=5, R2=9. Cycle1 R1out+Yin; cycle2 R2out+SelectY+Add+Zin; cycle3 Zout+R1in → Z=14 after cycle2, R1=14 after cycle3, Busy never set.
- Sub wrap and constant operand: Y=3, R2=5, SelectY+Sub+Zin with R2out → Z=0xFE. Then SelectY=0, Add+Zin, R2out → Z=6.
- Mul: Y=12, R2=13, Zin+Mul+SelectY with R2out at t0 → Busy high exactly 8 cycles, Z=156 (0x9C) at t0+8. Zin+Add asserted during Busy leaves Z unchanged.
- Div and divide-by-zero: Y=100, R1=7 → Z=14 after 8 cycles. Then Y=5, B=0 → Z=0xFF, DivByZero=1 and stays 1 through later ops until reset.
- Bus priority/conflict: R1=1, R2=2, Z=3. R1out+R2out → Bus=1. Zout+R1out → Bus=3. BusConflict=1 with BUS_CHECK_EN defined, 0 without.

Source files
------------

// File: rtl/datapath_unit.sv
// datapath_unit: single-bus register/ALU datapath (R1, R2, Y, Z).
// Add/Sub complete in one cycle; Mul (shift-add) and Div (restoring
// shift-subtract) iterate one bit per cycle and hold Busy for WIDTH cycles.
// Optional macro BUS_CHECK_EN builds the sticky multi-driver detector
// behind BusConflict; without it BusConflict is tied low.
module datapath_unit #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             R1in,
  input  logic             R1out,
  input  logic             R2in,
  input  logic             R2out,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             Zout,
  input  logic             SelectY,
  input  logic             Add,
  input  logic             Sub,
  input  logic             Mul,
  input  logic             Div,
  input  logic             ExtLoad,
  input  logic             ExtSel,
  input  logic [WIDTH-1:0] ExtData,
  output logic [WIDTH-1:0] Bus,
  output logic [WIDTH-1:0] R1Value,
  output logic [WIDTH-1:0] R2Value,
  output logic [WIDTH-1:0] ZValue,
  output logic             Busy,
  output logic             Zero,
  output logic             DivByZero,
  output logic             BusConflict
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  // Architectural registers
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] y_q,  y_d;
  logic [WIDTH-1:0] z_q,  z_d;

  // Iterative-unit state: opa holds multiplicand (shifting left) or
  // dividend/quotient (shifting left); opb holds multiplier (shifting right)
  // or the constant divisor; acc holds partial product or partial remainder.
  logic             busy_q,   busy_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opa_q,    opa_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic             dz_q,     dz_d;

  logic [WIDTH-1:0] bus_w;
  logic [WIDTH-1:0] a_op;

  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_quot_next;

  // Bus source selection with Zout > R1out > R2out priority, 0 when undriven
  always_comb begin
    bus_w = '0;
    if (Zout)       bus_w = z_q;
    else if (R1out) bus_w = r1_q;
    else if (R2out) bus_w = r2_q;
  end

  // A operand: Y or the constant 1
  always_comb begin
    a_op = SelectY ? y_q : WIDTH'(1);
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_acc_next  = acc_q + (opb_q[0] ? opa_q : '0);
    div_shift     = {acc_q, opa_q[WIDTH-1]};
    div_diff      = div_shift - {1'b0, opb_q};
    // A clear sign bit means the trial subtraction did not underflow
    div_ok        = ~div_diff[WIDTH];
    div_quot_next = {opa_q[WIDTH-2:0], div_ok};
  end

  // Next-state for registers, ALU result and the iterative unit
  always_comb begin
    r1_d     = r1_q;
    r2_d     = r2_q;
    y_d      = y_q;
    z_d      = z_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    dz_d     = dz_q;

    // Bus loads; the external preload wins for its target register
    if (ExtLoad && !ExtSel) r1_d = ExtData;
    else if (R1in)          r1_d = bus_w;
    if (ExtLoad && ExtSel)  r2_d = ExtData;
    else if (R2in)          r2_d = bus_w;
    if (Yin)                y_d  = bus_w;

    if (busy_q) begin
      // Zin and op selects are ignored while iterating
      cnt_d = cnt_q + CNT_W'(1);
      if (is_div_q) begin
        opa_d = div_quot_next;
        acc_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      end else begin
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        acc_d = mul_acc_next;
      end
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (is_div_q) begin
          // A zero divisor naturally yields an all-ones quotient
          z_d = div_quot_next;
          if (opb_q == '0) dz_d = 1'b1;
        end else begin
          z_d = mul_acc_next;
        end
      end
    end else if (Zin) begin
      if (Add) begin
        z_d = a_op + bus_w;
      end else if (Sub) begin
        z_d = a_op - bus_w;
      end else if (Mul || Div) begin
        busy_d   = 1'b1;
        cnt_d    = '0;
        is_div_d = !Mul;
        opa_d    = a_op;
        opb_d    = bus_w;
        acc_d    = '0;
      end else begin
        z_d = bus_w;
      end
    end
  end

  // State registers, all cleared asynchronously (aborts any iteration)
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r1_q     <= '0;
      r2_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      y_q      <= y_d;
      z_q      <= z_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      dz_q     <= dz_d;
    end
  end

`ifdef BUS_CHECK_EN
  logic bc_q, bc_d;
  logic multi_drv;

  // Sticky flag set whenever two or more bus drivers are enabled together
  always_comb begin
    multi_drv = (R1out & R2out) | (R1out & Zout) | (R2out & Zout);
    bc_d      = bc_q | multi_drv;
  end

  // Conflict flag register, cleared only by reset
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) bc_q <= 1'b0;
    else        bc_q <= bc_d;
  end

  assign BusConflict = bc_q;
`else
  assign BusConflict = 1'b0;
`endif

  assign Bus       = bus_w;
  assign R1Value   = r1_q;
  assign R2Value   = r2_q;
  assign ZValue    = z_q;
  assign Busy      = busy_q;
  assign Zero      = (z_q == '0);
  assign DivByZero = dz_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed scenarios followed by
// randomized traffic, compared against an arithmetic reference model.
module tb_datapath_unit;

  localparam int W = 8;
`ifdef BUS_CHECK_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         R1in, R1out, R2in, R2out, Yin, Zin, Zout, SelectY;
  logic         Add, Sub, Mul, Div, ExtLoad, ExtSel;
  logic [W-1:0] ExtData;
  logic [W-1:0] Bus, R1Value, R2Value, ZValue;
  logic         Busy, Zero, DivByZero, BusConflict;

  datapath_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset),
    .R1in(R1in), .R1out(R1out), .R2in(R2in), .R2out(R2out),
    .Yin(Yin), .Zin(Zin), .Zout(Zout), .SelectY(SelectY),
    .Add(Add), .Sub(Sub), .Mul(Mul), .Div(Div),
    .ExtLoad(ExtLoad), .ExtSel(ExtSel), .ExtData(ExtData),
    .Bus(Bus), .R1Value(R1Value), .R2Value(R2Value), .ZValue(ZValue),
    .Busy(Busy), .Zero(Zero), .DivByZero(DivByZero), .BusConflict(BusConflict)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_r1, m_r2, m_y, m_z, m_pend;
  int           m_left;
  bit           m_pend_dz, m_dz, m_bc;
  logic [W-1:0] bus_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_bus();
    if (Zout)  return m_z;
    if (R1out) return m_r1;
    if (R2out) return m_r2;
    return '0;
  endfunction

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_y = '0; m_z = '0; m_pend = '0;
    m_left = 0; m_pend_dz = 0; m_dz = 0; m_bc = 0;
  endtask

  // Effect of one rising edge on the architectural state
  task automatic model_edge();
    logic [W-1:0] b, a;
    b = model_bus();
    a = SelectY ? m_y : W'(1);
    if (BC_EN && (int'(R1out) + int'(R2out) + int'(Zout)) >= 2) m_bc = 1;
    if (ExtLoad && !ExtSel) m_r1 = ExtData; else if (R1in) m_r1 = b;
    if (ExtLoad && ExtSel)  m_r2 = ExtData; else if (R2in) m_r2 = b;
    if (Yin) m_y = b;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_z = m_pend;
        if (m_pend_dz) m_dz = 1;
      end
    end else if (Zin) begin
      if (Add)      m_z = W'(int'(a) + int'(b));
      else if (Sub) m_z = W'(int'(a) - int'(b));
      else if (Mul) begin
        m_pend = W'(int'(a) * int'(b)); m_pend_dz = 0; m_left = W;
      end else if (Div) begin
        m_pend_dz = (b == 0);
        m_pend = (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
        m_left = W;
      end else m_z = b;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".r1"},   R1Value,     m_r1);
    chk({tag, ".r2"},   R2Value,     m_r2);
    chk({tag, ".z"},    ZValue,      m_z);
    chk({tag, ".busy"}, Busy,        (m_left > 0));
    chk({tag, ".zero"}, Zero,        (m_z == 0));
    chk({tag, ".dz"},   DivByZero,   m_dz);
    chk({tag, ".bc"},   BusConflict, m_bc);
  endtask

  task automatic idle();
    R1in = 0; R1out = 0; R2in = 0; R2out = 0; Yin = 0; Zin = 0; Zout = 0;
    SelectY = 0; Add = 0; Sub = 0; Mul = 0; Div = 0; ExtLoad = 0; ExtSel = 0;
    ExtData = '0;
  endtask

  // One clock: bus checked mid-cycle, state checked just after the edge
  task automatic step(input string tag);
    @(negedge Clock);
    bus_seen = Bus;
    chk({tag, ".bus"}, Bus, model_bus());
    @(posedge Clock);
    model_edge();
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b0;
    model_reset();
    #1 check_state({tag, ".async"});
    @(posedge Clock);
    #1 check_state({tag, ".held"});
    Reset = 1'b1;
  endtask

  task automatic ext(input bit sel, input logic [W-1:0] v);
    idle(); ExtLoad = 1; ExtSel = sel; ExtData = v;
    step("ext");
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    do_reset("por");
    chk("por.zero_flag", Zero, 1);

    // Reset in the middle of a multiply
    ext(0, 8'd6);
    idle(); R1out = 1; Mul = 1; Zin = 1; step("mrst.start");
    chk("mrst.busy", Busy, 1);
    idle();
    for (int i = 0; i < 3; i++) step("mrst.run");
    @(negedge Clock);
    do_reset("mrst");
    idle();
    for (int i = 0; i < W + 2; i++) step("mrst.after");
    chk("mrst.z_never_written", ZValue, 0);
    chk("mrst.r1_cleared", R1Value, 0);

    // Add through Y
    ext(0, 8'd5);
    ext(1, 8'd9);
    idle(); R1out = 1; Yin = 1; step("add.y");
    idle(); R2out = 1; SelectY = 1; Add = 1; Zin = 1; step("add.op");
    chk("add.z14", ZValue, 14);
    chk("add.nobusy", Busy, 0);
    idle(); Zout = 1; R1in = 1; step("add.wb");
    chk("add.r1_14", R1Value, 14);

    // Sub wrap, then constant-1 operand
    ext(0, 8'd3);
    idle(); R1out = 1; Yin = 1; step("sub.y");
    ext(1, 8'd5);
    idle(); R2out = 1; SelectY = 1; Sub = 1; Zin = 1; step("sub.op");
    chk("sub.zfe", ZValue, 8'hFE);
    idle(); R2out = 1; Add = 1; Zin = 1; step("const.op");
    chk("const.z6", ZValue, 6);

    // Multiply: Busy for exactly W cycles, ignored ops during Busy
    ext(0, 8'd12);
    idle(); R1out = 1; Yin = 1; step("mul.y");
    ext(1, 8'd13);
    idle(); R2out = 1; SelectY = 1; Mul = 1; Zin = 1; step("mul.t0");
    chk("mul.busy_t0", Busy, 1);
    idle(); R2out = 1; Add = 1; Zin = 1;
    for (int i = 1; i < W; i++) begin
      step("mul.run");
      chk("mul.busy_run", Busy, 1);
      chk("mul.z_hold", ZValue, 6);
    end
    idle(); R2out = 1; SelectY = 1; Mul = 1; Zin = 1; step("mul.done");
    chk("mul.z156", ZValue, 8'h9C);
    chk("mul.busy_low", Busy, 0);
    idle(); step("mul.b2b_ignored");
    chk("mul.b2b_nobusy", Busy, 0);

    // Divide, then divide by zero
    ext(0, 8'd100);
    idle(); R1out = 1; Yin = 1; step("div.y");
    ext(0, 8'd7);
    idle(); R1out = 1; SelectY = 1; Div = 1; Zin = 1; step("div.t0");
    idle();
    for (int i = 0; i < W; i++) step("div.run");
    chk("div.z14", ZValue, 14);
    chk("div.nodz", DivByZero, 0);
    ext(0, 8'd5);
    idle(); R1out = 1; Yin = 1; step("dz.y");
    idle(); SelectY = 1; Div = 1; Zin = 1; step("dz.t0");
    idle();
    for (int i = 0; i < W; i++) step("dz.run");
    chk("dz.zff", ZValue, 8'hFF);
    chk("dz.flag", DivByZero, 1);
    idle(); R1out = 1; SelectY = 1; Add = 1; Zin = 1; step("dz.later");
    chk("dz.sticky", DivByZero, 1);

    // Bus priority and conflict detection
    ext(0, 8'd3);
    idle(); R1out = 1; Zin = 1; step("bus.z3");
    ext(0, 8'd1);
    ext(1, 8'd2);
    idle(); R1out = 1; R2out = 1; step("bus.r1r2");
    chk("bus.r1_over_r2", bus_seen, 1);
    idle(); Zout = 1; R1out = 1; step("bus.zr1");
    chk("bus.z_over_r1", bus_seen, 3);
    chk("bus.conflict", BusConflict, BC_EN);

    // Randomized traffic with one reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        @(negedge Clock);
        do_reset("rnd.rst");
      end
      R1in = ($urandom_range(0, 3) == 0); R2in = ($urandom_range(0, 3) == 0);
      Yin = ($urandom_range(0, 2) == 0);
      R1out = $urandom_range(0, 1); R2out = $urandom_range(0, 1);
      Zout = ($urandom_range(0, 3) == 0);
      Zin = ($urandom_range(0, 4) < 2); SelectY = $urandom_range(0, 1);
      Add = ($urandom_range(0, 3) == 0); Sub = ($urandom_range(0, 3) == 0);
      Mul = ($urandom_range(0, 2) == 0); Div = ($urandom_range(0, 2) == 0);
      ExtLoad = ($urandom_range(0, 3) == 0); ExtSel = $urandom_range(0, 1);
      ExtData = W'($urandom);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
